// File: rtl/sdmod.sv
// ---------------------------------------------------------------------------
// sdmod -- soft-decision front end of the RX bit path.
//
// Accepts one complex FFT bin per cycle (64 bins per OFDM symbol), drops the
// DC/guard nulls and the four pilots, hard-demaps the 48 QPSK data bins to
// 96 coded bits in 802.11a logical order, and replays each symbol as one
// contiguous 96-cycle serial burst. Two 96-bit banks ping-pong between the
// write side and the reader; upstream is throttled through di_rdy.
//
// Parameters
//   DW         width of di_re / di_im (signed two's complement)
//   BURST_GAP  minimum idle cycles between consecutive bursts (0..15)
//
// Ports
//   clk      in   1   clock, all state on rising edge
//   rst      in   1   asynchronous reset, active high
//   di_re    in   DW  FFT bin real part, signed
//   di_im    in   DW  FFT bin imaginary part, signed
//   di_vld   in   1   bin valid; beat accepted when di_vld & di_rdy
//   di_sop   in   1   accepted beat is bin 0 of a symbol
//   di_rdy   out  1   write bank can accept a beat
//   do_bit   out  1   serial coded bit (holds last value while do_vld=0)
//   do_vld   out  1   high for exactly 96 consecutive cycles per symbol
//   do_sop   out  1   high with the first bit of each burst
//   err_sop  out  1   one-cycle pulse on a framing error
// ---------------------------------------------------------------------------
module sdmod #(
   parameter int DW        = 16,
   parameter int BURST_GAP = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] di_re,
   input  logic [DW-1:0] di_im,
   input  logic          di_vld,
   input  logic          di_sop,
   output logic          di_rdy,
   output logic          do_bit,
   output logic          do_vld,
   output logic          do_sop,
   output logic          err_sop
);

   // ------------------------------------------------------------------------
   // Types and constants
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FULL,
      BANK_READING
   } bank_st_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_BURST,
      R_GAP
   } rd_state_t;

   localparam int         NBITS    = 96;
   localparam logic [5:0] LAST_BIN = 6'd63;
   localparam logic [6:0] LAST_BIT = 7'(NBITS - 1);
   localparam logic [3:0] GAP_LOAD = 4'(BURST_GAP - 1);

   // ------------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------------
   logic [NBITS-1:0] bank_mem [2];
   bank_st_t         bank_st  [2];

   logic             wr_sel;
   logic [5:0]       bin_cnt;

   rd_state_t        state;
   rd_state_t        state_nx;
   logic             rd_sel;
   logic [6:0]       bit_idx;
   logic [6:0]       bit_idx_nx;
   logic [3:0]       gap_cnt;
   logic [3:0]       gap_cnt_nx;
   logic             do_hold;

   // Write-side decode
   logic             accept;
   logic             sop_err;
   logic             orphan;
   logic             sym_done;
   logic [5:0]       bin_idx;
   logic [5:0]       k_idx;
   logic             k_vld;
   logic             wr_en;

   // Reader bank hand-shake events
   logic             rd_free;
   logic             rd_claim;
   logic             claim_sel;
   logic             cur_full;
   logic             other_full;

   // Only the sign bits carry information for a hard QPSK decision.
   logic             unused_mag;
   assign unused_mag = ^{di_re[DW-2:0], di_im[DW-2:0]};

   // ------------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------------
   // Ready depends only on registered bank state, never on the reader's
   // same-cycle decisions, so a freed bank shows up one cycle later.
   assign di_rdy   = (bank_st[wr_sel] == BANK_EMPTY);
   assign accept   = di_vld & di_rdy;

   // A sop in mid-symbol restarts the symbol in the same bank; a non-sop beat
   // while waiting for bin 0 is thrown away.
   assign sop_err  = accept &  di_sop & (bin_cnt != 6'd0);
   assign orphan   = accept & ~di_sop & (bin_cnt == 6'd0);
   assign bin_idx  = di_sop ? 6'd0 : bin_cnt;
   assign sym_done = accept & ~di_sop & (bin_cnt == LAST_BIN);
   assign wr_en    = accept & ~orphan & k_vld;

   // FFT bin -> logical data-carrier index. Negative frequencies (bins 38..63)
   // come first, then positive (1..26); nulls and pilots fall to default.
   // NOTE: every output of an always_comb gets a default first, otherwise a
   // path that skips the assignment infers a latch.
   always_comb begin
      k_vld = 1'b1;
      k_idx = 6'd0;
      case (bin_idx) inside
         [6'd38:6'd42]: k_idx = bin_idx - 6'd38;
         [6'd44:6'd56]: k_idx = bin_idx - 6'd39;
         [6'd58:6'd63]: k_idx = bin_idx - 6'd40;
         [6'd1:6'd6]:   k_idx = bin_idx + 6'd23;
         [6'd8:6'd20]:  k_idx = bin_idx + 6'd22;
         [6'd22:6'd26]: k_idx = bin_idx + 6'd21;
         default:       k_vld = 1'b0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_cnt <= 6'd0;
         wr_sel  <= 1'b0;
         err_sop <= 1'b0;
      end else begin
         err_sop <= sop_err | orphan;
         if (accept) begin
            if (di_sop) begin
               bin_cnt <= 6'd1;
            end else if (orphan || sym_done) begin
               bin_cnt <= 6'd0;
            end else begin
               bin_cnt <= bin_cnt + 6'd1;
            end
         end
         if (sym_done) begin
            wr_sel <= ~wr_sel;
         end
      end
   end

   // Every symbol rewrites all 96 bits, and bank_st gates every read, so the
   // payload needs no clearing.
   // NOTE: the bank payload is deliberately left out of reset; only the
   // control state that qualifies it is reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         bank_mem[wr_sel][{k_idx, 1'b0}] <= ~di_re[DW-1];
         bank_mem[wr_sel][{k_idx, 1'b1}] <= ~di_im[DW-1];
      end
   end

   // Bank ownership. The writer only completes a bank that is EMPTY and the
   // reader only touches FULL/READING banks, so the updates never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_st[0] <= BANK_EMPTY;
         bank_st[1] <= BANK_EMPTY;
      end else begin
         if (sym_done) begin
            bank_st[wr_sel] <= BANK_FULL;
         end
         if (rd_free) begin
            bank_st[rd_sel] <= BANK_EMPTY;
         end
         if (rd_claim) begin
            bank_st[claim_sel] <= BANK_READING;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Reader FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= R_IDLE;
         bit_idx <= 7'd0;
         gap_cnt <= 4'd0;
         rd_sel  <= 1'b0;
      end else begin
         state   <= state_nx;
         bit_idx <= bit_idx_nx;
         gap_cnt <= gap_cnt_nx;
         if (rd_free) begin
            rd_sel <= ~rd_sel;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Reader FSM: next state
   // ------------------------------------------------------------------------
   assign cur_full   = (bank_st[rd_sel]  == BANK_FULL);
   assign other_full = (bank_st[~rd_sel] == BANK_FULL);

   always_comb begin
      state_nx   = state;
      bit_idx_nx = bit_idx;
      gap_cnt_nx = gap_cnt;
      rd_free    = 1'b0;
      rd_claim   = 1'b0;
      claim_sel  = rd_sel;
      case (state)
         R_IDLE: begin
            if (cur_full) begin
               state_nx   = R_BURST;
               bit_idx_nx = 7'd0;
               rd_claim   = 1'b1;
            end
         end
         R_BURST: begin
            if (bit_idx == LAST_BIT) begin
               rd_free = 1'b1;
               if (BURST_GAP == 0) begin
                  // Chain straight into the other bank with no idle cycle.
                  if (other_full) begin
                     state_nx   = R_BURST;
                     bit_idx_nx = 7'd0;
                     rd_claim   = 1'b1;
                     claim_sel  = ~rd_sel;
                  end else begin
                     state_nx = R_IDLE;
                  end
               end else begin
                  state_nx   = R_GAP;
                  gap_cnt_nx = GAP_LOAD;
               end
            end else begin
               bit_idx_nx = bit_idx + 7'd1;
            end
         end
         R_GAP: begin
            // rd_sel already points at the next bank here. Leaving the gap
            // launches a waiting burst directly, so the idle stretch is
            // exactly BURST_GAP cycles when a bank is ready.
            if (gap_cnt == 4'd0) begin
               if (cur_full) begin
                  state_nx   = R_BURST;
                  bit_idx_nx = 7'd0;
                  rd_claim   = 1'b1;
               end else begin
                  state_nx = R_IDLE;
               end
            end else begin
               gap_cnt_nx = gap_cnt - 4'd1;
            end
         end
         default: begin
            state_nx = R_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Reader FSM: outputs
   // ------------------------------------------------------------------------
   // Outputs decode registered state only, so reset removes do_vld at once.
   always_comb begin
      do_vld = 1'b0;
      do_sop = 1'b0;
      do_bit = do_hold;
      if (state == R_BURST) begin
         do_vld = 1'b1;
         do_sop = (bit_idx == 7'd0);
         do_bit = bank_mem[rd_sel][bit_idx];
      end
   end

   // Remembers the last emitted bit so do_bit is stable between bursts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         do_hold <= 1'b0;
      end else if (do_vld) begin
         do_hold <= do_bit;
      end
   end

endmodule

// File: tb/tb_sdmod.sv
// ---------------------------------------------------------------------------
// tb_sdmod -- directed self-checking bench for sdmod.
// u_dut0 runs with BURST_GAP=0, u_dut3 with BURST_GAP=3; sel_g steers the
// shared input stream to one of them. A negedge monitor records every output
// sample into traces that the directed steps inspect afterwards.
// ---------------------------------------------------------------------------
module tb_sdmod;
   localparam int DW = 16;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [DW-1:0] di_re;
   logic signed [DW-1:0] di_im;
   logic                 di_vld;
   logic                 di_sop;
   logic                 sel_g;

   logic di_vld0, di_rdy0, do_bit0, do_vld0, do_sop0, err_sop0;
   logic di_vld1, di_rdy1, do_bit1, do_vld1, do_sop1, err_sop1;
   logic rdy;

   assign di_vld0 = di_vld & ~sel_g;
   assign di_vld1 = di_vld &  sel_g;
   assign rdy     = sel_g ? di_rdy1 : di_rdy0;

   always #5 clk = ~clk;

   sdmod #(.DW(DW), .BURST_GAP(0)) u_dut0 (
      .clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im),
      .di_vld(di_vld0), .di_sop(di_sop), .di_rdy(di_rdy0),
      .do_bit(do_bit0), .do_vld(do_vld0), .do_sop(do_sop0), .err_sop(err_sop0)
   );

   sdmod #(.DW(DW), .BURST_GAP(3)) u_dut3 (
      .clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im),
      .di_vld(di_vld1), .di_sop(di_sop), .di_rdy(di_rdy1),
      .do_bit(do_bit1), .do_vld(do_vld1), .do_sop(do_sop1), .err_sop(err_sop1)
   );

   // ------------------------------------------------------------------------
   // Output traces, one entry per clock (sampled on the falling edge)
   // ------------------------------------------------------------------------
   logic vld_tr[$], bit_tr[$], sop_tr[$], err_tr[$];
   logic vld1_tr[$], bit1_tr[$], sop1_tr[$];

   always @(negedge clk) begin
      vld_tr.push_back(do_vld0);
      bit_tr.push_back(do_bit0);
      sop_tr.push_back(do_sop0);
      err_tr.push_back(err_sop0);
      vld1_tr.push_back(do_vld1);
      bit1_tr.push_back(do_bit1);
      sop1_tr.push_back(do_sop1);
   end

   // ------------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------------
   int nvec = 0;
   int nfail = 0;
   int last_idx = 0;
   int cur_sym = 0;
   int first_stall_sym = -1;

   logic signed [DW-1:0] sym_re [64];
   logic signed [DW-1:0] sym_im [64];
   logic [95:0]          exp_q  [4];

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      nvec++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference carrier map, written from the 802.11a carrier table.
   function automatic int k_of(input int b);
      if (b >= 38 && b <= 42) return b - 38;
      if (b >= 44 && b <= 56) return b - 39;
      if (b >= 58 && b <= 63) return b - 40;
      if (b >= 1  && b <= 6)  return b + 23;
      if (b >= 8  && b <= 20) return b + 22;
      if (b >= 22 && b <= 26) return b + 21;
      return -1;
   endfunction

   function automatic logic [95:0] model_bits();
      logic [95:0] m;
      m = '0;
      for (int b = 0; b < 64; b++) begin
         int k;
         k = k_of(b);
         if (k >= 0) begin
            m[2*k]   = ~sym_re[b][DW-1];
            m[2*k+1] = ~sym_im[b][DW-1];
         end
      end
      return m;
   endfunction

   task automatic fill_pattern(input int j);
      for (int b = 0; b < 64; b++) begin
         sym_re[b] = (((b*5 + j*3) % 7) < 3) ? DW'(-(b+1)) : DW'(b+1);
         sym_im[b] = (((b*3 + j*5) % 4) < 2) ? DW'(-(b+2)) : DW'(b+2);
      end
   endtask

   function automatic int find_sop0(input int from);
      for (int i = from; i < sop_tr.size(); i++) if (sop_tr[i] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int find_sop1(input int from);
      for (int i = from; i < sop1_tr.size(); i++) if (sop1_tr[i] === 1'b1) return i;
      return -1;
   endfunction

   // which: 0 = do_vld, 1 = do_sop, 2 = err_sop of u_dut0; 3 = do_vld of u_dut3
   function automatic int count_tr(input int which, input int from, input int to);
      int n;
      n = 0;
      for (int i = from; i < to && i < vld_tr.size(); i++) begin
         if (i < 0) continue;
         case (which)
            0: if (vld_tr[i]  === 1'b1) n++;
            1: if (sop_tr[i]  === 1'b1) n++;
            2: if (err_tr[i]  === 1'b1) n++;
            default: if (vld1_tr[i] === 1'b1) n++;
         endcase
      end
      return n;
   endfunction

   function automatic logic [95:0] burst_bits(input int which, input int s);
      logic [95:0] v;
      v = 'x;
      if (s >= 0 && s + 96 <= bit_tr.size()) begin
         for (int i = 0; i < 96; i++) v[i] = (which == 0) ? bit_tr[s+i] : bit1_tr[s+i];
      end
      return v;
   endfunction

   // Called and returns at posedge+1; the beat is accepted at the next edge
   // that sees di_rdy high.
   task automatic send_beat(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                            input logic sop);
      int waits;
      waits  = 0;
      di_re  = re;
      di_im  = im;
      di_sop = sop;
      di_vld = 1'b1;
      while (rdy !== 1'b1 && waits < 1000) begin
         @(posedge clk);
         #1;
         waits++;
      end
      if (waits > 0 && first_stall_sym < 0) first_stall_sym = cur_sym;
      if (waits >= 1000) check("rdy_timeout", 96'(rdy), 96'd1);
      last_idx = vld_tr.size();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sym();
      for (int b = 0; b < 64; b++) send_beat(sym_re[b], sym_im[b], b == 0);
      di_vld = 1'b0;
      di_sop = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      int base, s, s_prev, lastb;
      int sops [4];

      rst = 1'b1; di_re = '0; di_im = '0; di_vld = 1'b0; di_sop = 1'b0; sel_g = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      check("rst_do_vld",  96'(do_vld0),  96'd0);
      check("rst_do_sop",  96'(do_sop0),  96'd0);
      check("rst_err_sop", 96'(err_sop0), 96'd0);
      check("rst_do_bit",  96'(do_bit0),  96'd0);
      check("rst_di_rdy",  96'(di_rdy0),  96'd1);
      check("rst_di_rdy_g3", 96'(di_rdy1), 96'd1);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // 1: data +100/-100, nulls/pilots -1 -> alternating 1,0
      for (int b = 0; b < 64; b++) begin
         sym_re[b] = (k_of(b) >= 0) ? 16'sd100  : -16'sd1;
         sym_im[b] = (k_of(b) >= 0) ? -16'sd100 : -16'sd1;
      end
      base = vld_tr.size();
      send_sym();
      lastb = last_idx;
      wait_cyc(110);
      s = find_sop0(base);
      check("t1_latency",  96'(s), 96'(lastb + 2));
      check("t1_bits",     burst_bits(0, s), 96'h5555_5555_5555_5555_5555_5555);
      check("t1_vld_cnt",  96'(count_tr(0, base, vld_tr.size())), 96'd96);
      check("t1_vld_run",  96'(count_tr(0, s, s + 96)), 96'd96);
      check("t1_sop_cnt",  96'(count_tr(1, base, vld_tr.size())), 96'd1);
      check("t1_idle_vld", 96'(do_vld0), 96'd0);

      // 2: bin 38 re=-5 im=0, bin 1 re=0 im=-5, rest +1
      for (int b = 0; b < 64; b++) begin
         sym_re[b] = 16'sd1;
         sym_im[b] = 16'sd1;
      end
      sym_re[38] = -16'sd5; sym_im[38] = 16'sd0;
      sym_re[1]  = 16'sd0;  sym_im[1]  = -16'sd5;
      base = vld_tr.size();
      send_sym();
      wait_cyc(110);
      s = find_sop0(base);
      check("t2_bits",    burst_bits(0, s), 96'hFFFF_FFFF_FFFD_FFFF_FFFF_FFFE);
      check("t2_do_hold", 96'(do_bit0), 96'd1);
      check("t2_err",     96'(count_tr(2, base, vld_tr.size())), 96'd0);

      // 3: four symbols back-to-back, continuous valid
      first_stall_sym = -1;
      base = vld_tr.size();
      for (int j = 0; j < 4; j++) begin
         cur_sym = j;
         fill_pattern(j);
         exp_q[j] = model_bits();
         send_sym();
      end
      wait_cyc(200);
      s_prev = base - 1;
      for (int j = 0; j < 4; j++) begin
         sops[j] = find_sop0(s_prev + 1);
         s_prev  = sops[j];
      end
      for (int j = 1; j < 4; j++)
         check($sformatf("t3_no_gap_%0d", j), 96'(sops[j]), 96'(sops[j-1] + 96));
      for (int j = 0; j < 4; j++)
         check($sformatf("t3_bits_%0d", j), burst_bits(0, sops[j]), exp_q[j]);
      check("t3_vld_cnt",     96'(count_tr(0, base, vld_tr.size())), 96'd384);
      check("t3_err",         96'(count_tr(2, base, vld_tr.size())), 96'd0);
      check("t3_first_stall", 96'(first_stall_sym), 96'd2);

      // 4: BURST_GAP=3 instance, two symbols
      sel_g = 1'b1;
      base = vld_tr.size();
      fill_pattern(4);
      send_sym();
      fill_pattern(5);
      exp_q[0] = model_bits();
      send_sym();
      wait_cyc(200);
      sops[0] = find_sop1(base);
      sops[1] = find_sop1(sops[0] + 1);
      check("t4_gap3",     96'(sops[1]), 96'(sops[0] + 99));
      check("t4_vld_span", 96'(count_tr(3, sops[0], sops[1])), 96'd96);
      check("t4_bits_2",   burst_bits(1, sops[1]), exp_q[0]);
      sel_g = 1'b0;
      wait_cyc(2);

      // 5a: sop arrives where bin 30 was due -> error, partial discarded
      base = vld_tr.size();
      fill_pattern(7);
      for (int b = 0; b < 30; b++) send_beat(sym_re[b], sym_im[b], b == 0);
      fill_pattern(9);
      exp_q[0] = model_bits();
      send_sym();
      wait_cyc(120);
      s = find_sop0(base);
      check("t5_err_cnt", 96'(count_tr(2, base, vld_tr.size())), 96'd1);
      check("t5_sop_cnt", 96'(count_tr(1, base, vld_tr.size())), 96'd1);
      check("t5_bits",    burst_bits(0, s), exp_q[0]);

      // 5b: beat without sop while waiting for bin 0 -> error, dropped
      base = vld_tr.size();
      send_beat(16'sd5, 16'sd5, 1'b0);
      di_vld = 1'b0;
      wait_cyc(100);
      check("t5_orphan_err", 96'(count_tr(2, base, vld_tr.size())), 96'd1);
      check("t5_orphan_vld", 96'(count_tr(0, base, vld_tr.size())), 96'd0);
      fill_pattern(10);
      exp_q[0] = model_bits();
      send_sym();
      wait_cyc(110);
      s = find_sop0(base);
      check("t5_after_err", 96'(count_tr(2, base, vld_tr.size())), 96'd1);
      check("t5_after_bits", burst_bits(0, s), exp_q[0]);

      // 6: reset at bit 40 of a burst
      fill_pattern(11);
      send_sym();
      s = 0;
      for (int i = 0; i < 200 && s == 0; i++) begin
         if (do_sop0 === 1'b1) s = 1;
         else wait_cyc(1);
      end
      check("t6_sop_seen", 96'(s), 96'd1);
      wait_cyc(40);
      check("t6_mid_vld", 96'(do_vld0), 96'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_vld", 96'(do_vld0), 96'd0);
      check("t6_rst_sop", 96'(do_sop0), 96'd0);
      check("t6_rst_rdy", 96'(di_rdy0), 96'd1);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      base = vld_tr.size();
      fill_pattern(12);
      exp_q[0] = model_bits();
      send_sym();
      lastb = last_idx;
      wait_cyc(110);
      s = find_sop0(base);
      check("t6_latency", 96'(s), 96'(lastb + 2));
      check("t6_bits",    burst_bits(0, s), exp_q[0]);
      check("t6_sop_cnt", 96'(count_tr(1, base, vld_tr.size())), 96'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
